// File: rtl/mac_sequencer.sv
// Control FSM for a multiply-accumulate datapath. It runs one dot product per command and presents the result.
// Latency: m_valid rises 2 cycles after the last beat is accepted. With taps=N and no bubbles, start to m_valid is N+2 cycles.
// Backpressure: s_ready is high only in RUN. In OUT the state holds until m_ready, with all enables low.
//
// Ports:
//   clk, reset (async, active-low)
//   start/cfg_taps : command strobe and beat count, sampled in IDLE only
//   abort          : synchronous return to IDLE from any state
//   s_valid/s_ready: upstream (i, k) pair handshake
//   r_enable       : datapath captures i*k into the product register
//   a_enable       : datapath accumulates the product into the output register
//   b_enable       : addend select for the accumulate (1 = bias, 0 = feedback)
//   m_valid/m_ready: result handshake; busy = not IDLE; done = one-cycle pulse after the result handshake
//   cont           : only when MAC_SEQ_CONT_EN is defined. It restarts RUN on the result handshake with the same taps.
module mac_sequencer #(
    parameter int TAP_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [TAP_W-1:0] cfg_taps,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             r_enable,
    output logic             a_enable,
    output logic             b_enable,
    output logic             m_valid,
    input  logic             m_ready,
`ifdef MAC_SEQ_CONT_EN
    input  logic             cont,
`endif
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    localparam logic [TAP_W-1:0] ONE = TAP_W'(1);

    state_t           state_q, state_d;
    logic [TAP_W-1:0] taps_q, taps_d;
    logic [TAP_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;    // a beat was accepted last cycle; accumulate it now
    logic             first_q, first_d;  // that pending beat was beat 0, so the addend is bias
    logic             done_q, done_d;
    logic             restart;

`ifdef MAC_SEQ_CONT_EN
    assign restart = cont;
`else
    assign restart = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            taps_q  <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            taps_q  <= taps_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            first_q <= first_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        taps_d  = taps_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
        first_d = 1'b0;
        done_d  = 1'b0;
        s_ready = 1'b0;
        m_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && (cfg_taps != '0)) begin
                    taps_d  = cfg_taps;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    pend_d  = 1'b1;
                    first_d = (cnt_q == '0);
                    cnt_d   = cnt_q + ONE;
                    if (cnt_q == taps_q - ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The final beat's accumulate happens here via pend_q.
                state_d = OUT;
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = restart ? RUN : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything except reset. The pending accumulate and any done pulse are dropped.
        if (abort) begin
            state_d = IDLE;
            pend_d  = 1'b0;
            first_d = 1'b0;
            done_d  = 1'b0;
        end
    end

    // The capture and the previous beat's accumulate overlap on purpose. The datapath reads the old product while the new one is written.
    assign r_enable = s_ready && s_valid;
    assign a_enable = pend_q;
    assign b_enable = pend_q && first_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;

endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
    localparam int TAP_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [TAP_W-1:0] cfg_taps = '0;
    logic             s_valid = 1'b0;
    logic             m_ready = 1'b0;
`ifdef MAC_SEQ_CONT_EN
    logic             cont = 1'b0;
`endif
    logic s_ready, r_enable, a_enable, b_enable, m_valid, busy, done;

    always #5 clk = ~clk;

    mac_sequencer #(.TAP_W(TAP_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_taps(cfg_taps),
        .s_valid(s_valid), .s_ready(s_ready), .r_enable(r_enable), .a_enable(a_enable),
        .b_enable(b_enable), .m_valid(m_valid), .m_ready(m_ready),
`ifdef MAC_SEQ_CONT_EN
        .cont(cont),
`endif
        .busy(busy), .done(done)
    );

    // Behavioural datapath driven by the sequencer's enables, plus pulse counters.
    logic [7:0]  cur_i = '0, cur_k = '0;
    logic [31:0] bias = '0, prod = '0, acc = '0;
    int          cyc = 0, r_cnt = 0, a_cnt = 0, b_cnt = 0, viol = 0;
    logic        prev_r = 1'b0, clr = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (r_enable) prod <= cur_i * cur_k;
        if (a_enable) acc <= (b_enable ? bias : acc) + prod;
        prev_r <= r_enable;
        if (clr) begin
            r_cnt <= 0; a_cnt <= 0; b_cnt <= 0; viol <= 0;
        end else begin
            r_cnt <= r_cnt + (r_enable ? 1 : 0);
            a_cnt <= a_cnt + (a_enable ? 1 : 0);
            b_cnt <= b_cnt + (b_enable ? 1 : 0);
            // An accumulate must follow each capture by exactly one cycle. The bias select is only legal during an accumulate.
            if ((a_enable != prev_r) || (b_enable && !a_enable)) viol <= viol + 1;
        end
    end

    int errors = 0, checks = 0;
    int qi[$], qk[$];
    int cur_taps = 0, st_cyc = 0, last_cyc = 0;
    logic [31:0] exp_res = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_random(input int n);
        qi.delete(); qk.delete();
        for (int b = 0; b < n; b++) begin
            qi.push_back(int'($urandom_range(0, 255)));
            qk.push_back(int'($urandom_range(0, 255)));
        end
    endtask

    task automatic do_start(input int taps);
        cur_taps = taps;
        clr = 1'b1; start = 1'b1; cfg_taps = TAP_W'(taps); st_cyc = cyc;
        tick();
        clr = 1'b0; start = 1'b0; cfg_taps = TAP_W'($urandom);
    endtask

    // Presents every queued pair. bub: 0 = none, 1 = two idle cycles before beat index 2, 2 = random single bubbles.
    task automatic feed(input int bub, input bit poke);
        exp_res = bias;
        for (int b = 0; b < qi.size(); b++) begin
            if ((bub == 1 && b == 2) || (bub == 2 && $urandom_range(0, 2) == 0)) begin
                s_valid = 1'b0;
                tick();
                if (bub == 1) tick();
            end
            cur_i = 8'(qi[b]); cur_k = 8'(qi[b] == qi[b] ? qk[b] : 0);
            s_valid = 1'b1;
            if (poke && b == 1) begin start = 1'b1; cfg_taps = TAP_W'(cur_taps + 3); end
            exp_res = exp_res + 32'(qi[b] * qk[b]);
            last_cyc = cyc;
            tick();
            start = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag, input int mdelay, input bit c, input bit nobub);
        int n;
        n = 0;
        while (!m_valid && n < 600) begin tick(); n++; end
        check({tag, "_mvalid"}, 32'(m_valid), 32'd1);
        check({tag, "_lat_last"}, 32'(cyc - last_cyc), 32'd2);
        if (nobub) check({tag, "_lat_start"}, 32'(cyc - st_cyc), 32'(cur_taps + 2));
        check({tag, "_result"}, acc, exp_res);
        check({tag, "_r_cnt"}, 32'(r_cnt), 32'(cur_taps));
        check({tag, "_a_cnt"}, 32'(a_cnt), 32'(cur_taps));
        check({tag, "_b_cnt"}, 32'(b_cnt), 32'd1);
        check({tag, "_viol"}, 32'(viol), 32'd0);
        // While the result waits, upstream keeps offering data. It must be refused.
        s_valid = 1'b1;
        for (int d = 0; d < mdelay; d++) begin
            check({tag, "_hold"}, {26'd0, m_valid, s_ready, r_enable, a_enable, b_enable, done}, 32'b100000);
            check({tag, "_hold_res"}, acc, exp_res);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1; clr = 1'b1; st_cyc = cyc;
`ifdef MAC_SEQ_CONT_EN
        cont = c;
`endif
        tick();
        m_ready = 1'b0; clr = 1'b0;
`ifdef MAC_SEQ_CONT_EN
        cont = 1'b0;
`endif
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_after"}, 32'(busy), 32'(c));
        if (!c) begin
            tick();
            check({tag, "_done_once"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int seen;
        reset = 1'b0;
        tick(); tick();
        check("reset_outputs", {25'd0, s_ready, r_enable, a_enable, b_enable, m_valid, busy, done}, 32'd0);
        reset = 1'b1;
        tick();

        // Directed: taps=3, bias=10, result 43; result held 5 cycles.
        bias = 32'd10;
        qi = '{2, 4, 1}; qk = '{3, 5, 7};
        do_start(3); feed(0, 1'b0);
        check("t1_model", exp_res, 32'd43);
        finish_cmd("t1", 5, 1'b0, 1'b1);
        check("t1_const", acc, 32'd43);

        // Directed: taps=1, bias=5, result 14, start to m_valid = 3.
        bias = 32'd5;
        qi = '{3}; qk = '{3};
        do_start(1); feed(0, 1'b0);
        finish_cmd("t2", 1, 1'b0, 1'b1);
        check("t2_const", acc, 32'd14);

        // Directed: bubble of two cycles before the third beat; result 30.
        bias = 32'd0;
        qi = '{1, 2, 3, 4}; qk = '{1, 2, 3, 4};
        do_start(4); feed(1, 1'b0);
        finish_cmd("t3", 5, 1'b0, 1'b0);
        check("t3_const", acc, 32'd30);

        // A start with taps=0 is ignored.
        start = 1'b1; cfg_taps = '0;
        tick();
        start = 1'b0;
        check("zero_taps_busy", 32'(busy), 32'd0);
        tick();
        check("zero_taps_busy2", 32'(busy), 32'd0);

        // Start during RUN is ignored (poke), and the taps change after the latch.
        bias = $urandom_range(0, 65535);
        load_random(5);
        do_start(5); feed(0, 1'b1);
        finish_cmd("poke", 2, 1'b0, 1'b1);

        // Randomized commands.
        for (int it = 0; it < 6; it++) begin
            int n;
            n = $urandom_range(1, 12);
            bias = $urandom;
            load_random(n);
            do_start(n); feed(2, 1'b0);
            finish_cmd("rand", $urandom_range(0, 3), 1'b0, 1'b0);
        end

        // Maximum tap count.
        bias = $urandom;
        load_random(255);
        do_start(255); feed(0, 1'b0);
        finish_cmd("max", 1, 1'b0, 1'b1);

        // Abort after 2 of 4 beats, while a third beat is being offered.
        bias = 32'd1;
        load_random(2);
        do_start(4); feed(0, 1'b0);
        s_valid = 1'b1; abort = 1'b1;
        tick();
        s_valid = 1'b0; abort = 1'b0;
        check("abort_state", {27'd0, busy, s_ready, m_valid, a_enable, done}, 32'd0);
        seen = 0;
        for (int d = 0; d < 8; d++) begin
            if (m_valid || done || busy) seen++;
            tick();
        end
        check("abort_quiet", 32'(seen), 32'd0);

        // Asynchronous reset mid-RUN with one beat taken.
        load_random(1);
        do_start(3); feed(0, 1'b0);
        s_valid = 1'b1;
        #2 reset = 1'b0;
        #1;
        check("reset_mid_run", {25'd0, s_ready, r_enable, a_enable, b_enable, m_valid, busy, done}, 32'd0);
        s_valid = 1'b0;
        @(negedge clk) reset = 1'b1;
        tick();
        bias = $urandom_range(0, 255);
        load_random(2);
        do_start(2); feed(0, 1'b0);
        finish_cmd("post_reset", 1, 1'b0, 1'b1);

`ifdef MAC_SEQ_CONT_EN
        // Back-to-back dot products without start.
        bias = 32'd7;
        load_random(3);
        do_start(3); feed(0, 1'b0);
        finish_cmd("cont1", 1, 1'b1, 1'b1);
        load_random(3);
        feed(0, 1'b0);
        finish_cmd("cont2", 1, 1'b0, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
